// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
package mux_scan_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam logic [SEL_W-1:0] LAST_CH = 2'd3;
endpackage

// File: rtl/scan_hold_timer.sv
// Down-counter that times how long each mux select is held before sampling y.
module scan_hold_timer #(
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Reload wins over decrement; counting stops at zero until the next reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_cnt <= '0;
    else if (clr)                   r_cnt <= '0;
    else if (load)                  r_cnt <= RELOAD;
    else if (en && r_cnt != '0)     r_cnt <= r_cnt - 1'b1;
  end

  assign expired = (r_cnt == '0);
endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the 4:1 mux select through all channels, samples y per channel and
// hands the assembled 4-bit frame out on a valid/ready handshake.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  output logic [SEL_W-1:0] sel,
  input  logic             y_in,
  output logic [NUM_CH-1:0] frame_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             busy
);
  scan_state_t       r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_sel, w_sel_nxt;
  logic [NUM_CH-2:0] r_buf, w_buf_nxt;
  logic [NUM_CH-1:0] r_data, w_data_nxt;
  logic              r_valid, w_valid_nxt;
  logic              w_clr, w_load, w_en, w_expired;

  scan_hold_timer #(.CNT_W(CNT_W), .HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_clr),
    .load    (w_load),
    .en      (w_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_buf   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_buf   <= w_buf_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_buf_nxt   = r_buf;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_clr       = 1'b0;
    w_load      = 1'b0;
    w_en        = 1'b0;
    // abort drops everything in flight but leaves the last delivered frame visible
    if (abort) begin
      w_state_nxt = IDLE;
      w_sel_nxt   = '0;
      w_buf_nxt   = '0;
      w_valid_nxt = 1'b0;
      w_clr       = 1'b1;
    end else begin
      unique case (r_state)
        IDLE: if (start) begin
          w_state_nxt = SCAN;
          w_sel_nxt   = '0;
          w_load      = 1'b1;
        end
        SCAN: if (!w_expired) begin
          w_en = 1'b1;
        end else if (r_sel != LAST_CH) begin
          for (int i = 0; i < NUM_CH - 1; i++)
            if (r_sel == SEL_W'(i)) w_buf_nxt[i] = y_in;
          w_sel_nxt = r_sel + 1'b1;
          w_load    = 1'b1;
        end else begin
          // last channel goes straight into the frame so the load is atomic
          w_data_nxt  = {y_in, r_buf};
          w_valid_nxt = 1'b1;
          w_state_nxt = DONE;
        end
        DONE: if (frame_ready) begin
          w_valid_nxt = 1'b0;
          w_sel_nxt   = '0;
          if (continuous) begin
            w_state_nxt = SCAN;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign sel         = r_sel;
  assign frame_data  = r_data;
  assign frame_valid = r_valid;
  assign busy        = (r_state != IDLE);
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed checks of mux_scan_ctrl with hold times of 1 and 3 cycles.
module tb_mux_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, continuous = 1'b0, abort = 1'b0, frame_ready = 1'b0;
  logic [3:0] abcd = 4'b0000;
  logic       y3 = 1'b0;
  logic [1:0] sel1, sel3;
  logic [3:0] data1, data3;
  logic       valid1, valid3, busy1, busy3, y1;
  int         n_pass = 0, n_chk = 0;

  always #5 clk = ~clk;

  assign y1 = abcd[sel1];

  mux_scan_ctrl #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .abort(abort),
    .sel(sel1), .y_in(y1), .frame_data(data1), .frame_valid(valid1),
    .frame_ready(frame_ready), .busy(busy1));

  mux_scan_ctrl #(.HOLD_CYCLES(3), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .abort(abort),
    .sel(sel3), .y_in(y3), .frame_data(data3), .frame_valid(valid3),
    .frame_ready(frame_ready), .busy(busy3));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0; frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #3;
    n_chk++; if (sel1 !== 2'd0) $display("FAIL rst_sel: got %0d exp 0", sel1); else n_pass++;
    n_chk++; if (data1 !== 4'h0) $display("FAIL rst_data: got %b exp 0000", data1); else n_pass++;
    n_chk++; if (valid1 !== 1'b0) $display("FAIL rst_valid: got %b exp 0", valid1); else n_pass++;
    n_chk++; if (busy1 !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy1); else n_pass++;
    n_chk++; if ({sel3, data3, valid3, busy3} !== 8'h00)
      $display("FAIL rst_dut3: got %b exp 00000000", {sel3, data3, valid3, busy3}); else n_pass++;
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    abcd = 4'b1101; frame_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (sel1 !== 2'(i) || valid1 !== 1'b0 || busy1 !== 1'b1)
        $display("FAIL basic_seq%0d: got sel=%0d v=%b b=%b exp sel=%0d v=0 b=1", i, sel1, valid1, busy1, i);
      else n_pass++;
      tick();
    end
    n_chk++; if (valid1 !== 1'b1 || data1 !== 4'b1101)
      $display("FAIL basic_frame: got v=%b d=%b exp v=1 d=1101", valid1, data1); else n_pass++;
    tick();
    n_chk++; if (valid1 !== 1'b0 || busy1 !== 1'b0 || sel1 !== 2'd0)
      $display("FAIL basic_idle: got v=%b b=%b sel=%0d exp v=0 b=0 sel=0", valid1, busy1, sel1); else n_pass++;
  endtask

  task automatic test_hold3();
    logic [3:0] fin;
    fin = 4'b0110;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 3; k++) begin
        y3 = (k == 1) ? ~fin[w] : fin[w];
        if (k == 0) y3 = ~fin[w];
        if (k == 2) y3 = fin[w];
        n_chk++; if (sel3 !== 2'(w) || valid3 !== 1'b0)
          $display("FAIL hold3_w%0d_k%0d: got sel=%0d v=%b exp sel=%0d v=0", w, k, sel3, valid3, w);
        else n_pass++;
        tick();
      end
    n_chk++; if (valid3 !== 1'b1 || data3 !== 4'b0110)
      $display("FAIL hold3_frame: got v=%b d=%b exp v=1 d=0110", valid3, data3); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    abcd = 4'b0010;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (valid1 !== 1'b1 || data1 !== 4'b0010 || sel1 !== 2'd3)
        $display("FAIL bp_hold%0d: got v=%b d=%b sel=%0d exp v=1 d=0010 sel=3", i, valid1, data1, sel1);
      else n_pass++;
      tick();
    end
    frame_ready = 1'b1; tick(); frame_ready = 1'b0;
    n_chk++; if (valid1 !== 1'b0 || busy1 !== 1'b0)
      $display("FAIL bp_xfer: got v=%b b=%b exp v=0 b=0", valid1, busy1); else n_pass++;
    tick();
    n_chk++; if (valid1 !== 1'b0 || busy1 !== 1'b0 || data1 !== 4'b0010)
      $display("FAIL bp_after: got v=%b b=%b d=%b exp v=0 b=0 d=0010", valid1, busy1, data1); else n_pass++;
  endtask

  task automatic test_continuous();
    do_reset();
    abcd = 4'b1010; continuous = 1'b1; frame_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      start = (c == 7);
      tick();
      n_chk++; if (valid1 !== (c == 4 || c == 9 || c == 14))
        $display("FAIL cont_valid_c%0d: got %b exp %b", c, valid1, (c == 4 || c == 9 || c == 14));
      else n_pass++;
      if (c == 5 || c == 10) begin
        n_chk++; if (sel1 !== 2'd0 || busy1 !== 1'b1)
          $display("FAIL cont_restart_c%0d: got sel=%0d b=%b exp sel=0 b=1", c, sel1, busy1); else n_pass++;
      end
      if (c == 9) begin
        n_chk++; if (data1 !== 4'b1010) $display("FAIL cont_data: got %b exp 1010", data1); else n_pass++;
      end
    end
    start = 1'b0; continuous = 1'b0; frame_ready = 1'b0;
  endtask

  task automatic test_abort();
    do_reset();
    abcd = 4'b0110; frame_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    abcd = 4'b1001;
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    n_chk++; if (sel1 !== 2'd2) $display("FAIL abort_pre: got sel=%0d exp 2", sel1); else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
    n_chk++; if (busy1 !== 1'b0 || sel1 !== 2'd0 || valid1 !== 1'b0 || data1 !== 4'b0110)
      $display("FAIL abort_idle: got b=%b sel=%0d v=%b d=%b exp b=0 sel=0 v=0 d=0110", busy1, sel1, valid1, data1);
    else n_pass++;
    tick();
    n_chk++; if (busy1 !== 1'b0) $display("FAIL abort_stay: got b=%b exp 0", busy1); else n_pass++;
    frame_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    n_chk++; if (valid1 !== 1'b1 || data1 !== 4'b1001)
      $display("FAIL abort_fresh: got v=%b d=%b exp v=1 d=1001", valid1, data1); else n_pass++;
  endtask

  task automatic test_async_reset();
    frame_ready = 1'b1; tick(); frame_ready = 1'b0;
    abcd = 4'b1111;
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    n_chk++; if (sel1 !== 2'd2 || busy1 !== 1'b1 || data1 !== 4'b1001)
      $display("FAIL arst_pre: got sel=%0d b=%b d=%b exp sel=2 b=1 d=1001", sel1, busy1, data1); else n_pass++;
    #2 rst_n = 1'b0; #1;
    n_chk++; if ({sel1, data1, valid1, busy1} !== 8'h00)
      $display("FAIL arst_now: got %b exp 00000000", {sel1, data1, valid1, busy1}); else n_pass++;
    n_chk++; if ({sel3, data3, valid3, busy3} !== 8'h00)
      $display("FAIL arst_now3: got %b exp 00000000", {sel3, data3, valid3, busy3}); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) tick();
    n_chk++; if ({sel1, valid1, busy1} !== 4'h0)
      $display("FAIL arst_quiet: got %b exp 0000", {sel1, valid1, busy1}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold3();
    test_backpressure();
    test_continuous();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Upstream sequencer for the 4:1 select mux.
- Drives the mux select pair {s1,s0} through channels 0..3 in order and holds each select for a programmable settle time.
- Samples the mux output y at the end of each hold window and assembles a 4-bit frame.
- Presents the frame on a valid/ready handshake, in single-shot or continuous scan mode.

Parameters:
- HOLD_CYCLES, 1, cycles each select value is held before y is sampled; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2**CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
- start  input  1  begin a scan; sampled only in IDLE.
- continuous  input  1  when 1, a new scan begins automatically after each frame is accepted.
- abort  input  1  synchronous abort; returns to IDLE and discards any partial or pending frame.
- sel  output  2  mux select; sel[1] drives s1, sel[0] drives s0.
- y_in  input  1  mux output y.
- frame_data  output  4  captured frame; bit i is the y value sampled while sel==i.
- frame_valid  output  1  frame_data holds a complete frame.
- frame_ready  input  1  consumer accepts the frame when frame_valid && frame_ready.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, sel=2'b00, hold cnt=0, capture buffer=0, frame_data=4'b0000, frame_valid=0, busy=0.
- States: IDLE, SCAN, DONE.
- IDLE -> SCAN on the edge where start=1 and abort=0. At that edge: sel<=0, cnt<=HOLD_CYCLES-1.
- SCAN:
  - Each edge with cnt!=0: cnt decrements; sel held.
  - Edge with cnt==0: capture y_in into buffer bit sel.
    - If sel<3: sel<=sel+1, cnt<=HOLD_CYCLES-1.
    - If sel==3: frame_data <= {y_in, buf[2:0]} (atomic load), frame_valid<=1, state<=DONE; sel stays 3.
- Latency: frame_valid rises exactly 4*HOLD_CYCLES edges after the start edge.
  - HOLD_CYCLES=1: sel sequence 0,1,2,3 on consecutive cycles.
- DONE:
  - frame_valid held high; frame_data stable; sel held at 3.
  - On transfer (frame_valid && frame_ready): frame_valid<=0.
    - If continuous=1 at that edge: sel<=0, cnt<=HOLD_CYCLES-1, state<=SCAN (next frame after a further 4*HOLD_CYCLES edges).
    - Otherwise: state<=IDLE, sel<=0.
- frame_data changes only on the SCAN->DONE load; it holds its value in IDLE and SCAN.
- start is ignored outside IDLE; continuous is only consulted at the transfer edge.
- abort=1 (any state, highest priority over start and transfer): state<=IDLE, sel<=0, cnt<=0, frame_valid<=0, capture buffer cleared; frame_data retains its last value.
- An async reset mid-scan or mid-DONE forces the full reset state immediately, without waiting for a clock edge.
- Counter wrap: cnt never underflows; it is reloaded whenever it reaches 0 in SCAN.
- Outputs are registered; no combinational path from any input to any output.

Decomposition:
- Package mux_scan_pkg:
  - state enum scan_state_t {IDLE, SCAN, DONE};
  - constants NUM_CH=4, SEL_W=2, LAST_CH=2'd3.
- One sub-module, scan_hold_timer (params CNT_W, HOLD_CYCLES).
  - Inputs: clk, rst_n, load, en.
  - Output: expired (cnt==0).
  - The top level owns the FSM, sel, capture buffer and output registers.

Test Plan:
- HOLD_CYCLES=1; mux inputs a=1, b=0, c=1, d=1; pulse start -> sel 0,1,2,3 on consecutive cycles; frame_valid rises 4 edges after start; frame_data=4'b1101; with frame_ready=1, back to IDLE, busy=0.
- HOLD_CYCLES=3; y toggles during the first two cycles of each window; final-cycle values 0,1,1,0 -> frame_data=4'b0110; frame_valid at edge 12; each sel value held exactly 3 cycles.
- Backpressure: frame_ready=0 for 5 cycles after frame_valid -> frame_valid and frame_data stable, sel=3; ready=1 -> one transfer only; frame_valid low on the next cycle.
- continuous=1, frame_ready tied 1, HOLD_CYCLES=1 -> sel=0 on the cycle after the transfer; frames every 5 cycles; start pulses during SCAN are ignored.
- abort asserted while sel=2 in SCAN -> next cycle IDLE, sel=0, frame_valid=0, frame_data unchanged; a fresh start yields a correct, uncorrupted frame.
- rst_n driven low mid-SCAN, between clock edges -> all outputs reach reset values immediately; after release, no activity until start.
